pla_seq: RTL

Clocked, parametrised successor to the combinational C64 PLA core. Inputs are synchronised, then matched against a run-time programmable AND/OR plane with per-output polarity and a per-output programmable delay line, which replaces the fixed inverter-chain delay on the CAS output. A configuration state machine gates table writes and holds outputs at a safe level until the pipeline has refilled.

---
 rtl/pla_seq_if.sv | 19 +
 rtl/pla_seq.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/pla_seq_if.sv
// pla_seq_if: configuration port of pla_seq.
//   cfg_en    master->slave  level; request and hold configuration mode
//   cfg_we    master->slave  write strobe, honoured only in CONFIG
//   cfg_addr  master->slave  write address (ADDR_W bits)
//   cfg_wdata master->slave  write data (N_IN bits)
//   cfg_ack   slave->master  one-cycle pulse, cycle after an accepted write
interface pla_seq_if #(
    parameter int ADDR_W = 8,
    parameter int N_IN   = 16
) ();
    logic              cfg_en;
    logic              cfg_we;
    logic [ADDR_W-1:0] cfg_addr;
    logic [N_IN-1:0]   cfg_wdata;
    logic              cfg_ack;

    modport master (output cfg_en, cfg_we, cfg_addr, cfg_wdata, input cfg_ack);
    modport slave  (input cfg_en, cfg_we, cfg_addr, cfg_wdata, output cfg_ack);
endinterface

// File: rtl/pla_seq.sv
// pla_seq: clocked, run-time programmable PLA.
// Inputs are synchronised, matched against a programmable AND/OR plane,
// XORed with a per-output polarity, registered, then delayed per output by
// 0..2^DELAY_W-1 cycles. A config FSM (RUN/CONFIG/WARM) gates table writes
// and holds outputs at the polarity value until the pipeline has refilled.
//   clk      clock, rising edge
//   rst      synchronous reset, active high
//   pin_i    asynchronous PLA inputs (N_IN)
//   pout_o   PLA outputs (N_OUT)
//   busy_o   high whenever the FSM is not in RUN
//   cfg      pla_seq_if.slave configuration port
// Optional macro GLITCH_FILTER_EN: adds a per-output 2-cycle stability
// filter after the delay line (+1 cycle latency, warm-up one cycle longer).
module pla_seq #(
    parameter int N_IN        = 16,
    parameter int N_OUT       = 8,
    parameter int N_TERMS     = 32,
    parameter int SYNC_STAGES = 2,
    parameter int DELAY_W     = 3,
    parameter int ADDR_W      = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_IN-1:0]  pin_i,
    output logic [N_OUT-1:0] pout_o,
    output logic             busy_o,
    pla_seq_if.slave         cfg
);
    localparam int MAXD = (1 << DELAY_W) - 1;
`ifdef GLITCH_FILTER_EN
    localparam int W = SYNC_STAGES + 1 + MAXD + 1;
`else
    localparam int W = SYNC_STAGES + 1 + MAXD;
`endif
    localparam int CNT_W = $clog2(W + 1);
    localparam int TW    = ADDR_W - 2;
    localparam logic [ADDR_W-1:0] POL_A = ADDR_W'(4 * N_TERMS);

    typedef enum logic [1:0] {RUN, CONFIG, WARM} state_e;

    state_e               state_q;
    logic [CNT_W-1:0]     cnt_q;
    logic                 ack_q;
    logic [N_IN-1:0]      care_q [N_TERMS];
    logic [N_IN-1:0]      val_q  [N_TERMS];
    logic [N_OUT-1:0]     or_q   [N_TERMS];
    logic [N_OUT-1:0]     pol_q;
    logic [N_OUT-1:0][DELAY_W-1:0] dly_q;
    logic [SYNC_STAGES-1:0][N_IN-1:0] sync_q;
    logic [N_OUT-1:0]     ev_d, ev_q;
    logic [N_OUT-1:0][MAXD-1:0] hist_q;
    logic [N_OUT-1:0][MAXD:0]   line;
    logic [N_OUT-1:0]     dly_out;
    logic [N_OUT-1:0]     out_v;
    logic                 wr_en;

    // A write landing in the same cycle cfg_en drops is discarded.
    assign wr_en       = (state_q == CONFIG) && cfg.cfg_en && cfg.cfg_we;
    assign cfg.cfg_ack = ack_q;
    assign busy_o      = (state_q != RUN);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= WARM;
            cnt_q   <= '0;
            ack_q   <= 1'b0;
        end else begin
            ack_q <= wr_en;
            case (state_q)
                RUN:    if (cfg.cfg_en) state_q <= CONFIG;
                CONFIG: if (!cfg.cfg_en) begin
                            state_q <= WARM;
                            cnt_q   <= '0;
                        end
                WARM:   if (cfg.cfg_en) begin
                            state_q <= CONFIG;
                            cnt_q   <= '0;
                        end else if (cnt_q == CNT_W'(W - 1)) begin
                            state_q <= RUN;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                default: state_q <= WARM;
            endcase
        end
    end

    // Programmable table; unmapped and reserved addresses fall through.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int t = 0; t < N_TERMS; t++) begin
                care_q[t] <= '0;
                val_q[t]  <= '0;
                or_q[t]   <= '0;
            end
            pol_q <= '1;
            dly_q <= '0;
        end else if (wr_en) begin
            for (int t = 0; t < N_TERMS; t++) begin
                if (cfg.cfg_addr[ADDR_W-1:2] == TW'(t)) begin
                    case (cfg.cfg_addr[1:0])
                        2'd0:    care_q[t] <= cfg.cfg_wdata;
                        2'd1:    val_q[t]  <= cfg.cfg_wdata;
                        2'd2:    or_q[t]   <= cfg.cfg_wdata[N_OUT-1:0];
                        default: ;
                    endcase
                end
            end
            if (cfg.cfg_addr == POL_A) pol_q <= cfg.cfg_wdata[N_OUT-1:0];
            for (int k = 0; k < N_OUT; k++) begin
                if (cfg.cfg_addr == ADDR_W'(4 * N_TERMS + 1 + k))
                    dly_q[k] <= cfg.cfg_wdata[DELAY_W-1:0];
            end
        end
    end

    always_comb begin
        logic [N_OUT-1:0] raw;
        raw = '0;
        for (int t = 0; t < N_TERMS; t++) begin
            if (&(~care_q[t] | ~(sync_q[SYNC_STAGES-1] ^ val_q[t])))
                raw = raw | or_q[t];
        end
        ev_d = raw ^ pol_q;
    end

    // line[k][d] is ev_k as it was d cycles ago; index 0 is the live value.
    always_comb begin
        for (int k = 0; k < N_OUT; k++) begin
            line[k]    = {hist_q[k], ev_q[k]};
            dly_out[k] = line[k][dly_q[k]];
        end
    end

    // Synchroniser and delay lines run in every state so RUN starts with history.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
            ev_q   <= '0;
            hist_q <= '0;
        end else begin
            sync_q[0] <= pin_i;
            for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
            ev_q <= ev_d;
            for (int k = 0; k < N_OUT; k++) hist_q[k] <= line[k][MAXD-1:0];
        end
    end

`ifdef GLITCH_FILTER_EN
    // Compare the delayed value now with the one it takes after this edge,
    // so a value that holds for two cycles passes with only one cycle of lag.
    logic [N_OUT-1:0][MAXD:0] nline;
    logic [N_OUT-1:0]         nxt;
    logic [N_OUT-1:0]         filt_q;

    always_comb begin
        for (int k = 0; k < N_OUT; k++) begin
            nline[k] = {line[k][MAXD-1:0], ev_d[k]};
            nxt[k]   = nline[k][dly_q[k]];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            filt_q <= '0;
        end else begin
            for (int k = 0; k < N_OUT; k++)
                if (nxt[k] == dly_out[k]) filt_q[k] <= nxt[k];
        end
    end
    assign out_v = filt_q;
`else
    assign out_v = dly_out;
`endif

    assign pout_o = (state_q == RUN) ? out_v : pol_q;
endmodule
